dcache_wb: RTL

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_wb.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines.
// Misses stall the CPU while a dirty victim is written back and the line is refilled.
module dcache_wb #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          data_address_2DC,
    input  logic                 read_2DC,
    input  logic                 write_2DC,
    input  logic [31:0]          data_write_2DC,
    input  logic [1:0]           data_write_size_2DC,
    input  logic                 flush_2DC,
    output logic [31:0]          data_read_fDC,
    output logic                 data_valid_fDC,
    output logic                 flush_done,
    output logic [31:0]          data_address_2DM,
    output logic                 dBlkRead,
    input  logic [LINE_BITS-1:0] block_read_fDM,
    input  logic                 block_read_fDM_valid,
    output logic                 dBlkWrite,
    output logic [LINE_BITS-1:0] block_write_2DM,
    input  logic                 block_write_fDM_valid
);

    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = 32 - 5 - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB,
        FLUSH_DONE
    } state_t;

    state_t state, next_state;

    logic [LINE_BITS-1:0] data_mem [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [INDEX_BITS-1:0] flush_index;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [2:0]            req_word;
    logic [1:0]            req_lane;
    logic                  req_pending;
    logic                  hit;
    logic                  flush_last;
    logic [LINE_BITS-1:0]  req_line;
    logic [LINE_BITS-1:0]  flush_line;
    logic [LINE_BITS-1:0]  merged_line;
    logic [31:0]           req_word_data;

    logic fill_line;
    logic write_hit;
    logic victim_clean;
    logic flush_clear;
    logic flush_advance;
    logic flush_restart;

    assign req_tag       = data_address_2DC[31 -: TAG_BITS];
    assign req_index     = data_address_2DC[5 +: INDEX_BITS];
    assign req_word      = data_address_2DC[4:2];
    assign req_lane      = data_address_2DC[1:0];
    assign req_pending   = read_2DC || write_2DC;
    assign req_line      = data_mem[req_index];
    assign flush_line    = data_mem[flush_index];
    assign req_word_data = req_line[int'(req_word)*32 +: 32];
    assign hit           = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign flush_last    = (flush_index == LAST_INDEX);

    // Byte lanes past lane 3 fall off the end of the word and are discarded.
    always_comb begin
        int nbytes;
        merged_line = req_line;
        nbytes = (data_write_size_2DC == 2'd0) ? 4 : int'(data_write_size_2DC);
        for (int lane = 0; lane < 4; lane++) begin
            if (lane >= int'(req_lane) && lane < int'(req_lane) + nbytes) begin
                merged_line[int'(req_word)*32 + lane*8 +: 8] = data_write_2DC[lane*8 +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every output and strobe gets a default first so no path can infer a latch.
        next_state       = state;
        data_read_fDC    = '0;
        data_valid_fDC   = 1'b0;
        flush_done       = 1'b0;
        data_address_2DM = '0;
        dBlkRead         = 1'b0;
        dBlkWrite        = 1'b0;
        block_write_2DM  = '0;
        fill_line        = 1'b0;
        write_hit        = 1'b0;
        victim_clean     = 1'b0;
        flush_clear      = 1'b0;
        flush_advance    = 1'b0;
        flush_restart    = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_pending) begin
                    if (hit) begin
                        data_valid_fDC = 1'b1;
                        if (read_2DC) data_read_fDC = req_word_data;
                        write_hit = write_2DC;
                    end else if (valid[req_index] && dirty[req_index]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end else if (flush_2DC) begin
                    next_state    = FLUSH_SCAN;
                    flush_restart = 1'b1;
                end else begin
                    data_valid_fDC = 1'b1;
                end
            end

            WRITEBACK: begin
                dBlkWrite        = 1'b1;
                data_address_2DM = {tag_mem[req_index], req_index, 5'b0};
                block_write_2DM  = req_line;
                if (block_write_fDM_valid) begin
                    victim_clean = 1'b1;
                    next_state   = FILL;
                end
            end

            // The CPU holds its request, so the live address still names the line.
            FILL: begin
                dBlkRead         = 1'b1;
                data_address_2DM = {data_address_2DC[31:5], 5'b0};
                if (block_read_fDM_valid) begin
                    fill_line  = 1'b1;
                    next_state = IDLE;
                end
            end

            FLUSH_SCAN: begin
                if (valid[flush_index] && dirty[flush_index]) begin
                    next_state = FLUSH_WB;
                end else begin
                    flush_clear = 1'b1;
                    if (flush_last) next_state = FLUSH_DONE;
                    else flush_advance = 1'b1;
                end
            end

            FLUSH_WB: begin
                dBlkWrite        = 1'b1;
                data_address_2DM = {tag_mem[flush_index], flush_index, 5'b0};
                block_write_2DM  = flush_line;
                if (block_write_fDM_valid) begin
                    flush_clear = 1'b1;
                    if (flush_last) begin
                        next_state = FLUSH_DONE;
                    end else begin
                        flush_advance = 1'b1;
                        next_state    = FLUSH_SCAN;
                    end
                end
            end

            FLUSH_DONE: begin
                flush_done = flush_2DC;
                if (!flush_2DC) begin
                    next_state    = IDLE;
                    flush_restart = 1'b1;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            flush_index <= '0;
        end else begin
            state <= next_state;
            if (fill_line) begin
                valid[req_index] <= 1'b1;
                dirty[req_index] <= 1'b0;
            end
            if (write_hit) dirty[req_index] <= 1'b1;
            if (victim_clean) dirty[req_index] <= 1'b0;
            if (flush_clear) begin
                valid[flush_index] <= 1'b0;
                dirty[flush_index] <= 1'b0;
            end
            if (flush_restart) flush_index <= '0;
            else if (flush_advance) flush_index <= flush_index + 1'b1;
        end
    end

    // NOTE: data and tag arrays are deliberately not reset; the valid bits make stale contents unreachable.
    always_ff @(posedge CLK) begin
        if (fill_line) begin
            data_mem[req_index] <= block_read_fDM;
            tag_mem[req_index]  <= req_tag;
        end else if (write_hit) begin
            data_mem[req_index] <= merged_line;
        end
    end

endmodule
